// File: rtl/mm_rd_req_arbiter.sv
// mm_rd_req_arbiter: shares the CCI-P c0 read-request channel among N_REQ
// fetch engines. The arbiter is round-robin and honours c0TxAlmFull. Each
// requester has a cap on outstanding reads. Responses are steered back to
// their requester by Mdata index, and a drain handshake supports job teardown.

// Per-requester outstanding-read counter
module mm_rd_req_cnt #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cntNext,
  output logic             atMax
);
  // An issue and a return in the same cycle cancel out
  always_comb begin
    cntNext = cnt;
    if (inc && !dec)      cntNext = cnt + 1'b1;
    else if (dec && !inc) cntNext = cnt - 1'b1;
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cntNext;
  end

  assign atMax = (cnt >= CNT_W'(MAX_OUTSTANDING));
endmodule

module mm_rd_req_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int MDATA_W         = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         c0_tx_valid,
  output logic [ADDR_W-1:0]            c0_tx_addr,
  output logic [MDATA_W-1:0]           c0_tx_mdata,
  input  logic                         c0_tx_almfull,
  input  logic                         c0_rx_valid,
  input  logic [MDATA_W-1:0]           c0_rx_mdata,
  input  logic [DATA_W-1:0]            c0_rx_data,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  input  logic                         drain_req,
  output logic                         drained,
  output logic                         err_bad_rsp
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  logic [1:0]                   state;
  logic [IDX_W-1:0]             rrPtr;
  logic                         canGrant;
  logic [N_REQ-1:0]             eligible;
  logic [N_REQ-1:0]             grant;
  logic                         anyGrant;
  logic [IDX_W-1:0]             grantIdx;
  logic [N_REQ-1:0]             atMax;
  logic [N_REQ-1:0]             rxHit;
  logic [N_REQ-1:0]             cntZeroNext;
  logic [N_REQ-1:0][CNT_W-1:0]  cnt;
  logic [N_REQ-1:0][CNT_W-1:0]  cntNext;
  logic [IDX_W-1:0]             rxIdx;
  logic                         rxUpperZero;
  logic                         rspBad;

  // Index arithmetic modulo N_REQ; arguments never exceed 2*N_REQ-2
  function automatic logic [IDX_W-1:0] wrapIdx(input int v);
    return IDX_W'((v >= N_REQ) ? v - N_REQ : v);
  endfunction

  // Grants are held off during reset, outside RUN, when drain is requested
  // in this very cycle, and under almost-full. A request that was already
  // registered still goes out, because the almfull slack covers it.
  assign canGrant = !reset && (state == ST_RUN) && !drain_req && !c0_tx_almfull;
  assign eligible = {N_REQ{canGrant}} & req_valid & ~atMax;

  // Round-robin pick: first eligible index at or after the pointer
  always_comb begin
    anyGrant = 1'b0;
    grantIdx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!anyGrant && eligible[wrapIdx(int'(rrPtr) + k)]) begin
        anyGrant = 1'b1;
        grantIdx = wrapIdx(int'(rrPtr) + k);
      end
    end
    grant = anyGrant ? (N_REQ'(1) << grantIdx) : '0;
  end

  assign req_ready = grant;

  // Response decode: a valid index requires zero upper Mdata bits, an index
  // below N_REQ, and a nonzero outstanding count. Anything else is dropped.
  assign rxIdx       = c0_rx_mdata[IDX_W-1:0];
  assign rxUpperZero = ((c0_rx_mdata >> IDX_W) == '0);

  // One-hot match of a good response to its requester
  always_comb begin
    rxHit = '0;
    for (int i = 0; i < N_REQ; i++)
      rxHit[i] = c0_rx_valid && rxUpperZero && (rxIdx == IDX_W'(i)) && (cnt[i] != '0);
  end

  assign rspBad = c0_rx_valid && (rxHit == '0);

  for (genvar i = 0; i < N_REQ; i++) begin : gLane
    mm_rd_req_cnt #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .CNT_W          (CNT_W)
    ) uCnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (grant[i]),
      .dec    (rxHit[i]),
      .cnt    (cnt[i]),
      .cntNext(cntNext[i]),
      .atMax  (atMax[i])
    );
    assign cntZeroNext[i] = (cntNext[i] == '0);
  end

  // Round-robin pointer moves past the winner only on a transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rrPtr <= '0;
    else if (anyGrant) rrPtr <= wrapIdx(int'(grantIdx) + 1);
  end

  // Issue register. Address and Mdata hold their value between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0_tx_valid <= 1'b0;
      c0_tx_addr  <= '0;
      c0_tx_mdata <= '0;
    end else begin
      c0_tx_valid <= anyGrant;
      if (anyGrant) begin
        c0_tx_addr  <= req_addr[grantIdx];
        c0_tx_mdata <= MDATA_W'(grantIdx);
      end
    end
  end

  // Response register plus sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid   <= '0;
      rsp_data    <= '0;
      err_bad_rsp <= 1'b0;
    end else begin
      rsp_valid <= rxHit;
      if (rxHit != '0) rsp_data <= c0_rx_data;
      if (rspBad)      err_bad_rsp <= 1'b1;
    end
  end

  // Drain FSM. DRAIN completes once every count is zero after this cycle's
  // updates and no issue is in flight, so drained rises the cycle after
  // the last response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:     if (drain_req) state <= ST_DRAIN;
        ST_DRAIN:   if ((&cntZeroNext) && !c0_tx_valid) state <= ST_DRAINED;
        ST_DRAINED: if (!drain_req) state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  assign drained = (state == ST_DRAINED);
endmodule

// File: tb/tb_mm_rd_req_arbiter.sv
// Self-checking bench for mm_rd_req_arbiter: directed scenarios plus a
// random phase, all checked each cycle against a transaction-level model.
module tb_mm_rd_req_arbiter;
  localparam int NR   = 2;
  localparam int AW   = 42;
  localparam int DW   = 64;
  localparam int MW   = 16;
  localparam int MAXO = 4;

  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NR-1:0]           req_valid = '0;
  logic [NR-1:0][AW-1:0]   req_addr = '0;
  logic [NR-1:0]           req_ready;
  logic                    c0_tx_valid;
  logic [AW-1:0]           c0_tx_addr;
  logic [MW-1:0]           c0_tx_mdata;
  logic                    c0_tx_almfull = 1'b0;
  logic                    c0_rx_valid = 1'b0;
  logic [MW-1:0]           c0_rx_mdata = '0;
  logic [DW-1:0]           c0_rx_data = '0;
  logic [NR-1:0]           rsp_valid;
  logic [DW-1:0]           rsp_data;
  logic                    drain_req = 1'b0;
  logic                    drained;
  logic                    err_bad_rsp;

  always #5 clk = ~clk;

  mm_rd_req_arbiter #(
    .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MDATA_W(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr),
    .c0_tx_mdata(c0_tx_mdata), .c0_tx_almfull(c0_tx_almfull),
    .c0_rx_valid(c0_rx_valid), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .drain_req(drain_req),
    .drained(drained), .err_bad_rsp(err_bad_rsp)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: counts of reads in flight, the next index to favour,
  // the drain mode, and the outputs expected after the coming clock edge.
  int            mCnt[NR];
  int            mPtr;
  int            mMode;
  bit            mTxValid;
  logic [AW-1:0] eTxAddr;
  logic [MW-1:0] eTxMdata;
  logic [NR-1:0] eRsp;
  logic [DW-1:0] eRspData;
  bit            eErr;

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mCnt[i] = 0;
    mPtr = 0; mMode = M_RUN; mTxValid = 0;
    eTxAddr = '0; eTxMdata = '0; eRsp = '0; eRspData = '0; eErr = 0;
  endtask

  // One clock: drive inputs, check the grant, advance the model, check outputs
  task automatic step(input logic [NR-1:0] rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic af, input logic rxv, input logic [MW-1:0] rxm, input logic dr);
    int g;
    int idx;
    bit good;
    bit allZero;
    logic [DW-1:0] d;
    logic [NR-1:0] expReady;
    @(negedge clk);
    d = {$urandom, $urandom};
    req_valid = rv; req_addr[0] = a0; req_addr[1] = a1;
    c0_tx_almfull = af; c0_rx_valid = rxv; c0_rx_mdata = rxm; c0_rx_data = d;
    drain_req = dr;
    #1;
    g = -1;
    if (mMode == M_RUN && !dr && !af)
      for (int k = 0; k < NR; k++) begin
        idx = (mPtr + k) % NR;
        if (g < 0 && rv[idx] && mCnt[idx] < MAXO) g = idx;
      end
    expReady = (g < 0) ? '0 : NR'(1 << g);
    chk("req_ready", 64'(req_ready), 64'(expReady));

    good = 0;
    if (rxv && rxm < NR) good = (mCnt[rxm] > 0);
    eRsp = good ? NR'(1 << rxm) : '0;
    if (good) eRspData = d;
    if (rxv && !good) eErr = 1;
    if (good) mCnt[rxm]--;
    if (g >= 0) begin
      mCnt[g]++;
      mPtr = (g + 1) % NR;
      eTxAddr = (g == 1) ? a1 : a0;
      eTxMdata = MW'(g);
    end
    allZero = 1;
    for (int i = 0; i < NR; i++) if (mCnt[i] != 0) allZero = 0;
    case (mMode)
      M_RUN:     if (dr) mMode = M_DRAIN;
      M_DRAIN:   if (allZero && !mTxValid) mMode = M_DRAINED;
      default:   if (!dr) mMode = M_RUN;
    endcase
    mTxValid = (g >= 0);

    @(posedge clk); #1;
    chk("c0_tx_valid", 64'(c0_tx_valid), 64'(mTxValid));
    chk("c0_tx_addr", 64'(c0_tx_addr), 64'(eTxAddr));
    chk("c0_tx_mdata", 64'(c0_tx_mdata), 64'(eTxMdata));
    chk("rsp_valid", 64'(rsp_valid), 64'(eRsp));
    chk("rsp_data", 64'(rsp_data), 64'(eRspData));
    chk("err_bad_rsp", 64'(err_bad_rsp), 64'(eErr));
    chk("drained", 64'(drained), 64'(mMode == M_DRAINED));
  endtask

  // Assert reset between edges with requests still pending. Outputs must
  // clear immediately, without waiting for a clock edge.
  task automatic doReset();
    @(negedge clk); #2;
    reset = 1'b1; #1;
    chk("rst req_ready", 64'(req_ready), 0);
    chk("rst c0_tx_valid", 64'(c0_tx_valid), 0);
    chk("rst c0_tx_addr", 64'(c0_tx_addr), 0);
    chk("rst c0_tx_mdata", 64'(c0_tx_mdata), 0);
    chk("rst rsp_valid", 64'(rsp_valid), 0);
    chk("rst rsp_data", 64'(rsp_data), 0);
    chk("rst drained", 64'(drained), 0);
    chk("rst err_bad_rsp", 64'(err_bad_rsp), 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0; c0_rx_valid = 1'b0; drain_req = 1'b0; c0_tx_almfull = 1'b0;
    modelReset();
  endtask

  // Random response to a requester with reads in flight, or a bad one
  task automatic pickRsp(input int badPct, output logic v, output logic [MW-1:0] m);
    int q[$];
    for (int i = 0; i < NR; i++) if (mCnt[i] > 0) q.push_back(i);
    v = 0; m = '0;
    if ($urandom_range(99) < badPct) begin
      v = 1; m = MW'($urandom_range(NR, 40));
    end else if (q.size() > 0 && $urandom_range(99) < 55) begin
      v = 1; m = MW'(q[$urandom_range(q.size() - 1)]);
    end
  endtask

  initial begin
    logic v;
    logic [MW-1:0] m;
    logic dr;
    modelReset();
    req_valid = 2'b11;
    doReset();

    // Single requester: issue 0x100, then its response
    step(2'b01, 42'h100, 42'h0, 0, 0, '0, 0);
    step(2'b00, 42'h0, 42'h0, 0, 1, 16'h0000, 0);
    step(2'b00, 42'h0, 42'h0, 0, 0, '0, 0);

    // Fairness: both valid for 8 cycles, and responses keep counts below the cap
    for (int c = 0; c < 8; c++)
      step(2'b11, 42'(32'hA000 + c), 42'(32'hB000 + c), 0, c >= 2, MW'(c % 2), 0);
    for (int c = 0; c < 2; c++) step(2'b00, '0, '0, 0, 1, MW'(c), 0);

    // Almfull mid-stream: the in-flight issue still leaves, then grants stop
    step(2'b11, 42'h11, 42'h22, 0, 0, '0, 0);
    for (int c = 0; c < 3; c++) step(2'b11, 42'h33, 42'h44, 1, 0, '0, 0);
    step(2'b11, 42'h55, 42'h66, 0, 0, '0, 0);
    doReset();

    // Limit: requester 0 fills up, requester 1 is still served, then one return
    for (int c = 0; c < 4; c++) step(2'b01, 42'(c), '0, 0, 0, '0, 0);
    for (int c = 0; c < 3; c++) step(2'b11, 42'h77, 42'h88, 0, 0, '0, 0);
    step(2'b11, 42'h77, 42'h88, 0, 1, 16'h0000, 0);
    step(2'b11, 42'h99, 42'hAA, 0, 0, '0, 0);
    doReset();

    // Simultaneous issue and return for requester 1 at count 3
    for (int c = 0; c < 3; c++) step(2'b10, '0, 42'(c), 0, 0, '0, 0);
    step(2'b10, '0, 42'h3, 0, 1, 16'h0001, 0);
    step(2'b10, '0, 42'h4, 0, 0, '0, 0);
    step(2'b10, '0, 42'h5, 0, 0, '0, 0);
    doReset();

    // Bad responses: zero count, then an out-of-range index
    step(2'b00, '0, '0, 0, 1, 16'h0000, 0);
    doReset();
    step(2'b00, '0, '0, 0, 1, 16'h0005, 0);
    step(2'b00, '0, '0, 0, 0, '0, 0);
    doReset();

    // Drain with 3 in flight while requests keep arriving, then release
    for (int c = 0; c < 3; c++) step(2'b01, 42'(c), '0, 0, 0, '0, 0);
    step(2'b11, 42'h1, 42'h2, 0, 0, '0, 1);
    for (int c = 0; c < 3; c++) begin
      step(2'b11, 42'h1, 42'h2, 0, 1, 16'h0000, 1);
      step(2'b11, 42'h1, 42'h2, 0, 0, '0, 1);
    end
    step(2'b11, 42'h1, 42'h2, 0, 0, '0, 1);
    step(2'b11, 42'h3, 42'h4, 0, 0, '0, 0);
    step(2'b11, 42'h5, 42'h6, 0, 0, '0, 0);

    // Random traffic with almfull, drain episodes and rare bad responses
    dr = 0;
    for (int c = 0; c < 2500; c++) begin
      pickRsp((c > 2000) ? 2 : 0, v, m);
      if (dr) dr = ($urandom_range(19) != 0);
      else    dr = ($urandom_range(39) == 0);
      step(NR'($urandom), AW'({$urandom, $urandom}), AW'({$urandom, $urandom}),
           ($urandom_range(7) == 0), v, m, dr);
      if (c == 1200) doReset();
    end

    // Reset mid-stream, then check that the counts restarted from zero
    step(2'b11, 42'h1, 42'h2, 0, 0, '0, 0);
    doReset();
    for (int c = 0; c < 10; c++) step(2'b01, 42'(c), '0, 0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/mm_rd_req_arbiter.md
Name: mm_rd_req_arbiter

Overview:
Shares the AFU-side CCI-P c0 read-request channel between N_REQ matrix-multiply fetch engines (e.g. matrix A row fetcher and matrix B column fetcher). It sits in app_afu between the fetch engines and the MPF afu-side c0 Tx/Rx signals. It arbitrates requests round-robin, honours c0TxAlmFull and caps outstanding reads per requester. It steers read responses back to their requester by Mdata and provides a drain handshake for job teardown.

Parameters:
N_REQ, 2, number of requesters (2..8); IDX_W = max(1, clog2(N_REQ)) derived
ADDR_W, 42, CCI-P cache-line address width
DATA_W, 512, read response data width
MDATA_W, 16, request/response Mdata width
MAX_OUTSTANDING, 64, per-requester limit on outstanding reads; CNT_W = clog2(MAX_OUTSTANDING+1) derived

Ports:
clk  in  1  AFU clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester read request valid
req_addr  in  N_REQ*ADDR_W  per-requester line address; slice i belongs to requester i
req_ready  out  N_REQ  grant; a request transfers when req_valid[i] & req_ready[i]
c0_tx_valid  out  1  read request valid toward MPF
c0_tx_addr  out  ADDR_W  read request address
c0_tx_mdata  out  MDATA_W  read request Mdata
c0_tx_almfull  in  1  c0TxAlmFull from MPF
c0_rx_valid  in  1  read response valid (rspValid & hdr type = read)
c0_rx_mdata  in  MDATA_W  read response Mdata
c0_rx_data  in  DATA_W  read response data
rsp_valid  out  N_REQ  one-hot response valid per requester
rsp_data  out  DATA_W  response data, common to all requesters
drain_req  in  1  level; stop granting and wait for all reads to return
drained  out  1  high while in DRAINED state
err_bad_rsp  out  1  sticky; response with invalid index or zero outstanding count

Behaviour:
- Reset (async assert, release synchronous to clk): all outputs 0, RR pointer 0, all counters 0, FSM in RUN.
- Eligibility of requester i: FSM = RUN, c0_tx_almfull = 0, req_valid[i] = 1, outstanding[i] < MAX_OUTSTANDING.
- Grant is combinational. req_ready is one-hot or zero. It selects the first eligible index at or after the pointer, with wrap at N_REQ-1 -> 0.
- On transfer by index g, the pointer becomes (g+1) mod N_REQ. With no transfer the pointer holds.
- Request latency is 1 cycle. The cycle after a transfer: c0_tx_valid = 1, c0_tx_addr = req_addr[g], c0_tx_mdata = g zero-extended to MDATA_W. Otherwise c0_tx_valid = 0, and addr/mdata hold their last value.
- c0_tx_almfull only blocks new grants. A request already registered is still issued; the CCI-P almfull slack absorbs it.
- At most one request per cycle. Back-to-back grants are allowed every cycle.
- outstanding[i] increments on transfer of i.
- outstanding[i] decrements on c0_rx_valid with c0_rx_mdata[IDX_W-1:0] = i and outstanding[i] > 0.
- If increment and decrement for the same i happen in the same cycle, outstanding[i] is unchanged.
- Responses return in any order. They are registered with 1-cycle latency: rsp_valid[idx] = 1 and rsp_data = c0_rx_data in the next cycle.
- Bad responses are dropped. A response is bad if idx >= N_REQ, upper Mdata bits are nonzero, or outstanding[idx] = 0. For a bad response: no rsp_valid, and err_bad_rsp is set. err_bad_rsp clears only on reset.
- FSM:
  - RUN -> DRAIN when drain_req = 1. Grants stop in the same cycle.
  - DRAIN -> DRAINED when all outstanding = 0 and c0_tx_valid = 0.
  - DRAINED -> RUN when drain_req = 0.
  - If drain_req drops while in DRAIN, the FSM still completes to DRAINED, then returns to RUN.
- drain_req asserted in the same cycle as an eligible request: no grant that cycle.
- No backpressure on rsp_valid. Requesters must always accept responses.

Test Plan:
- Single requester: req_valid = 01, addr 0x100 -> req_ready = 01 same cycle; next cycle c0_tx_valid = 1, addr 0x100, mdata 0x0000; response mdata 0x0000 -> rsp_valid = 01 one cycle later with matching data.
- Fairness: both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1…; c0_tx_mdata alternates 0,1; exactly 4 issues each.
- Almfull: assert c0_tx_almfull during streaming -> the request granted in the prior cycle still issues; then no grants until almfull drops; the pointer resumes at the next index.
- Limit: MAX_OUTSTANDING = 4, requester 0 issues 4 with no responses -> req_ready[0] stays 0 while requester 1 is still granted; one response to idx 0 -> requester 0 is granted the next cycle.
- Boundary/errors:
  - Simultaneous issue and response for idx 1 with count 3 -> count stays 3.
  - Response mdata 0x0005 with N_REQ = 2 -> dropped, err_bad_rsp = 1.
  - Response to idx 0 with count 0 -> dropped, err_bad_rsp = 1.
- Drain/reset:
  - drain_req with 3 outstanding -> no grants; drained rises the cycle after the last response returns; drain_req low -> RUN.
  - reset asserted mid-stream -> all outputs 0 immediately, counters cleared.
